// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding DEPTH-byte packets from N_REQ requesters into one byte-wide UART transmitter.
// Optional transmitter-stall abort is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0][DEPTH-1:0][7:0] req_data,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [N_REQ-1:0]                 grant,
  output logic [7:0]                       tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int PW = $clog2(N_REQ);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [PW-1:0]           r_ptr;
  logic [PW-1:0]           w_winner;
  logic                    w_found;
  logic [IW-1:0]           r_idx;
  logic [DEPTH-1:0][7:0]   r_buf;
  logic [N_REQ-1:0]        r_grant;
  logic                    r_done;
  logic                    w_accept;
  logic                    w_hs;
  logic                    w_last_hs;
  logic                    w_abort;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_err;
`endif

  // Rotating search: first requester at or after the priority pointer, wrapping.
  always_comb begin
    logic [PW-1:0] cand;
    int            c;
    w_found  = 1'b0;
    w_winner = '0;
    cand     = '0;
    c        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      c = int'(r_ptr) + k;
      if (c >= N_REQ) c = c - N_REQ;
      cand = PW'(c);
      if (!w_found && req_valid[cand]) begin
        w_found  = 1'b1;
        w_winner = cand;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_hs         = 1'b0;
    w_last_hs    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_accept     = 1'b1;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          w_hs = 1'b1;
          if (r_idx == IW'(DEPTH - 1)) begin
            w_last_hs    = 1'b1;
            w_state_next = S_IDLE;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = (r_state == S_IDLE) && w_found && (w_winner == PW'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_grant <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_last_hs;
      if (w_accept) begin
        r_grant <= N_REQ'(1) << w_winner;
        r_ptr   <= (w_winner == PW'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
        r_idx   <= '0;
      end else if (w_last_hs || w_abort) begin
        r_grant <= '0;
        r_idx   <= '0;
      end else if (w_hs) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Packet snapshot: requester may change its data once accepted.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf <= req_data[w_winner];
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (r_state == S_IDLE || w_hs) r_tmo_cnt <= '0;
      else                           r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign grant    = r_grant;
  assign tx_valid = (r_state == S_SEND);
  assign busy     = (r_state == S_SEND);
  assign tx_data  = (r_state == S_SEND) ? r_buf[r_idx] : 8'h00;
  assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized run against a packet-level model.
// Timeout scenario runs only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int D   = 4;
  localparam int TMO = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [N-1:0]             req_valid;
  logic [N-1:0][D-1:0][7:0] req_data;
  logic [N-1:0]             req_ready;
  logic [N-1:0]             grant;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic                     busy;
  logic                     done;
  logic                     err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .DEPTH(D), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; tx_ready = 1'b0; req_data = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    $display("reset: outputs checked");
  endtask

  task automatic test_single();
    logic [7:0] exp_b [4];
    exp_b = '{8'hAA, 8'h55, 8'hF0, 8'hF0};
    @(negedge clk);
    rst = 1'b0; tx_ready = 1'b1;
    req_data[0] = {8'hF0, 8'hF0, 8'h55, 8'hAA};
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_req_ready: got %b expected 0001", req_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      n_checks++; if ({tx_valid, tx_data} !== {1'b1, exp_b[k]}) begin n_fail++; $display("FAIL single_byte%0d: got v=%b d=%h expected v=1 d=%h", k, tx_valid, tx_data, exp_b[k]); end
      n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant%0d: got %b expected 0001", k, grant); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_early_done%0d: got %b expected 0", k, done); end
    end
    @(negedge clk); #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b expected 1", done); end
    n_checks++; if ({tx_valid, busy, grant} !== '0) begin n_fail++; $display("FAIL single_idle: got v=%b busy=%b grant=%b expected all 0", tx_valid, busy, grant); end
    @(negedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b expected 0", done); end
    $display("single: packet AA 55 F0 F0 from requester 0");
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    @(negedge clk);
    rst = 1'b0; tx_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[i] = $urandom;
    req_valid = '1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_first_ready: got %b expected 0001", req_ready); end
    for (int p = 0; p < 5; p++) begin
      g = p % N;
      for (int k = 0; k < D; k++) begin
        @(negedge clk); #1;
        n_checks++; if (grant !== oh(g)) begin n_fail++; $display("FAIL rr_grant p%0d b%0d: got %b expected %b", p, k, grant, oh(g)); end
        n_checks++; if (tx_data !== req_data[g][k]) begin n_fail++; $display("FAIL rr_data p%0d b%0d: got %h expected %h", p, k, tx_data, req_data[g][k]); end
      end
      @(negedge clk);
      if (p == 4) req_valid = '0;
      #1;
      n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rr_gap p%0d: got done=%b busy=%b expected done=1 busy=0", p, done, busy); end
      if (p < 4) begin
        n_checks++; if (req_ready !== oh((p + 1) % N)) begin n_fail++; $display("FAIL rr_next_ready p%0d: got %b expected %b", p, req_ready, oh((p + 1) % N)); end
      end
      $display("round_robin: packet %0d served requester %0d", p, g);
    end
  endtask

  task automatic test_backpressure();
    int         nhs;
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       last_prev;
    logic       saw_done;
    nhs = 0; prev_stall = 1'b0; prev_d = '0; last_prev = 1'b0; saw_done = 1'b0;
    do_reset();
    @(negedge clk);
    rst = 1'b0; tx_ready = 1'b0;
    req_data[0] = $urandom;
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_ready: got %b expected 0001", req_ready); end
    for (int c = 0; c < 40 && !saw_done; c++) begin
      @(negedge clk);
      req_valid = '0;
      tx_ready = (c % 3 == 0);
      #1;
      n_checks++; if (done !== last_prev) begin n_fail++; $display("FAIL bp_done c%0d: got %b expected %b", c, done, last_prev); end
      if (done) saw_done = 1'b1;
      last_prev = 1'b0;
      if (tx_valid) begin
        if (prev_stall) begin
          n_checks++; if (tx_data !== prev_d) begin n_fail++; $display("FAIL bp_hold c%0d: got %h expected %h", c, tx_data, prev_d); end
        end
        if (tx_ready) begin
          n_checks++;
          if (nhs >= D) begin n_fail++; $display("FAIL bp_extra_byte c%0d: got %h expected none", c, tx_data); end
          else if (tx_data !== req_data[0][nhs]) begin n_fail++; $display("FAIL bp_byte%0d: got %h expected %h", nhs, tx_data, req_data[0][nhs]); end
          nhs++;
          if (nhs == D) last_prev = 1'b1;
        end
        prev_stall = !tx_ready;
        prev_d = tx_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
    n_checks++; if (nhs != D) begin n_fail++; $display("FAIL bp_count: got %0d bytes expected %0d", nhs, D); end
    n_checks++; if (!saw_done) begin n_fail++; $display("FAIL bp_done_timeout: got no done expected done within 40 cycles"); end
    $display("backpressure: %0d bytes delivered", nhs);
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    rst = 1'b0; tx_ready = 1'b1;
    req_data[3] = $urandom;
    req_valid = 4'b1000;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_first: got %b expected 1000", req_ready); end
    repeat (D) begin
      @(negedge clk); req_valid = '0; #1;
      n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_grant3: got %b expected 1000", grant); end
    end
    @(negedge clk);
    req_valid = 4'b1010; req_data[1] = $urandom;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_to1: got %b expected 0010", req_ready); end
    repeat (D) begin
      @(negedge clk); req_valid = 4'b1000; #1;
      n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL wrap_grant1: got %b expected 0010", grant); end
    end
    @(negedge clk); #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_to3: got %b expected 1000", req_ready); end
    repeat (D) begin
      @(negedge clk); req_valid = '0; #1;
      n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_grant3b: got %b expected 1000", grant); end
    end
    @(negedge clk);
    $display("wrap: grants 3, 1, 3");
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    rst = 1'b0; tx_ready = 1'b1;
    req_data[0] = $urandom;
    req_valid = 4'b0001;
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    n_checks++; if (tx_data !== req_data[0][1]) begin n_fail++; $display("FAIL rmid_byte1: got %h expected %h", tx_data, req_data[0][1]); end
    rst = 1'b1;
    @(negedge clk);
    req_valid = '1;
    #1;
    n_checks++; if ({tx_valid, busy, grant, done} !== '0) begin n_fail++; $display("FAIL rmid_outputs: got v=%b busy=%b grant=%b done=%b expected all 0", tx_valid, busy, grant, done); end
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr: got %b expected 0001", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    req_data[2] = {8'h11, 8'h22, 8'h33, 8'hAA};
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rmid_ready2: got %b expected 0100", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    n_checks++; if (tx_data !== 8'hAA || grant !== 4'b0100) begin n_fail++; $display("FAIL rmid_first: got d=%h g=%b expected d=AA g=0100", tx_data, grant); end
    @(negedge clk); #1;
    n_checks++; if (tx_data !== 8'h33) begin n_fail++; $display("FAIL rmid_second: got %h expected 33", tx_data); end
    repeat (3) @(negedge clk);
    $display("reset_mid: packet dropped, requester 2 served from byte 0");
  endtask

  task automatic test_random();
    logic [D-1:0][7:0] pkt [N];
    bit                have [N];
    bit                m_idle;
    int                m_ptr, m_own, m_idx, w, c, served;
    logic [D-1:0][7:0] m_buf;
    bit                m_done;
    logic [N-1:0]      exp_rr, exp_gnt;
    m_idle = 1; m_ptr = 0; m_own = 0; m_idx = 0; m_buf = '0; m_done = 0; served = 0;
    for (int i = 0; i < N; i++) begin have[i] = 0; pkt[i] = '0; end
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!have[i] && $urandom_range(3) == 0) begin have[i] = 1; pkt[i] = $urandom; end
        req_valid[i] = have[i];
        req_data[i] = pkt[i];
      end
      tx_ready = ($urandom_range(9) < 7);
      #1;
      w = -1;
      if (m_idle) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (w < 0 && have[c]) w = c;
        end
      end
      exp_rr  = (w >= 0) ? oh(w) : '0;
      exp_gnt = m_idle ? '0 : oh(m_own);
      n_checks++; if (req_ready !== exp_rr) begin n_fail++; $display("FAIL rnd_req_ready c%0d: got %b expected %b", cyc, req_ready, exp_rr); end
      n_checks++; if (grant !== exp_gnt) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b expected %b", cyc, grant, exp_gnt); end
      n_checks++; if (tx_valid !== !m_idle || busy !== !m_idle) begin n_fail++; $display("FAIL rnd_valid c%0d: got v=%b busy=%b expected %b", cyc, tx_valid, busy, !m_idle); end
      n_checks++; if (done !== m_done) begin n_fail++; $display("FAIL rnd_done c%0d: got %b expected %b", cyc, done, m_done); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rnd_err c%0d: got %b expected 0", cyc, err); end
      if (!m_idle) begin
        n_checks++; if (tx_data !== m_buf[m_idx]) begin n_fail++; $display("FAIL rnd_data c%0d: got %h expected %h", cyc, tx_data, m_buf[m_idx]); end
      end
      m_done = 0;
      if (m_idle) begin
        if (w >= 0) begin
          m_buf = pkt[w]; have[w] = 0; m_own = w; m_ptr = (w + 1) % N; m_idx = 0; m_idle = 0;
        end
      end else if (tx_ready) begin
        if (m_idx == D - 1) begin
          m_idle = 1; m_done = 1; served++;
          $display("random: packet %0d from requester %0d data %h", served, m_own, m_buf);
        end else begin
          m_idx++;
        end
      end
    end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int stalls;
    bit seen_err;
    stalls = 0; seen_err = 0;
    do_reset();
    @(negedge clk);
    rst = 1'b0; tx_ready = 1'b1;
    req_data[0] = $urandom;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0010; req_data[1] = $urandom;
    #1;
    n_checks++; if (tx_data !== req_data[0][0]) begin n_fail++; $display("FAIL tmo_byte0: got %h expected %h", tx_data, req_data[0][0]); end
    for (int c = 0; c < 40 && !seen_err; c++) begin
      @(negedge clk); tx_ready = 1'b0; #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL tmo_done c%0d: got %b expected 0", c, done); end
      if (err) seen_err = 1;
      else if (tx_valid) stalls++;
    end
    n_checks++; if (!seen_err) begin n_fail++; $display("FAIL tmo_no_err: got no err expected err within 40 cycles"); end
    n_checks++; if (stalls != TMO) begin n_fail++; $display("FAIL tmo_stalls: got %0d expected %0d", stalls, TMO); end
    n_checks++; if ({tx_valid, busy, grant} !== '0) begin n_fail++; $display("FAIL tmo_idle: got v=%b busy=%b grant=%b expected all 0", tx_valid, busy, grant); end
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL tmo_next: got %b expected 0010", req_ready); end
    @(negedge clk); req_valid = '0; tx_ready = 1'b1; #1;
    n_checks++; if (err !== 1'b0 || grant !== 4'b0010) begin n_fail++; $display("FAIL tmo_after: got err=%b grant=%b expected err=0 grant=0010", err, grant); end
    repeat (D + 1) @(negedge clk);
    $display("timeout: aborted after %0d stalled cycles", stalls);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
